// File: rtl/alu_issue_stage_pkg.sv
// Shared constants and types for the ALU issue stage: ALU opcodes,
// instruction class encodings, funct3 values and the decode bundle.
package alu_issue_stage_pkg;

    localparam int XLEN = 64;

    // ALU opcodes as understood by the external 64-bit ALU
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;  // ALU computes A + ~B
    localparam logic [3:0] ALU_NOR = 4'b1100;  // supported by the ALU, never issued here

    // Instruction classes delivered by decode
    localparam logic [1:0] CLS_MEM = 2'b00;
    localparam logic [1:0] CLS_BR  = 2'b01;
    localparam logic [1:0] CLS_R   = 2'b10;
    localparam logic [1:0] CLS_I   = 2'b11;

    // funct3 values
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_EQ   = 2'b01,
        BR_NE   = 2'b10
    } br_kind_e;

    typedef struct packed {
        logic [3:0] op;       // ALU opcode to issue
        logic       b_imm;    // operand B comes from the immediate
        logic       is_sub;   // operand B must be pre-decremented
        br_kind_e   br_kind;  // branch condition, BR_NONE for non-branches
        logic       illegal;  // unsupported encoding
    } decode_t;

    // Branch resolution from the ALU Zero flag of A - B
    function automatic logic branch_taken(input br_kind_e kind, input logic zero);
        logic taken;
        case (kind)
            BR_EQ:   taken = zero;
            BR_NE:   taken = !zero;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decode-side, ALU-side and writeback-side signals of the issue stage.
// slave is the stage's view; master is the environment's view.
interface alu_issue_stage_if;
    import alu_issue_stage_pkg::*;

    // upstream (decode) handshake and fields
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_class;
    logic [2:0]      in_funct3;
    logic            in_funct7_5;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic [XLEN-1:0] in_imm;
    logic [4:0]      in_rd;

    // external ALU
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;

    // downstream handshake and result
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [4:0]      out_rd;
    logic            out_branch;
    logic            out_taken;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_class, in_funct3, in_funct7_5,
        input  in_rs1, in_rs2, in_imm, in_rd,
        output in_ready,
        output alu_a, alu_b, alu_op,
        input  alu_result, alu_zero,
        output out_valid, out_result, out_rd, out_branch, out_taken, out_illegal,
        input  out_ready
    );

    modport master (
        output in_valid, in_class, in_funct3, in_funct7_5,
        output in_rs1, in_rs2, in_imm, in_rd,
        input  in_ready,
        input  alu_a, alu_b, alu_op,
        output alu_result, alu_zero,
        input  out_valid, out_result, out_rd, out_branch, out_taken, out_illegal,
        output out_ready
    );

endinterface

// File: rtl/alu_issue_stage_decode.sv
// Purely combinational instruction decode: class/funct3/funct7_5 to ALU
// opcode, operand-B source, subtract flag, branch kind and illegal flag.
module alu_op_decode
    import alu_issue_stage_pkg::*;
(
    input  logic [1:0] cls,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output decode_t    dec
);

    // Map the encoding onto an ALU operation; unsupported encodings fall to illegal
    always_comb begin
        dec         = '0;
        dec.op      = ALU_ADD;
        dec.br_kind = BR_NONE;
        case (cls)
            CLS_MEM: begin
                dec.b_imm = 1'b1;
            end
            CLS_BR: begin
                case (funct3)
                    F3_BEQ: begin
                        dec.op      = ALU_SUB;
                        dec.is_sub  = 1'b1;
                        dec.br_kind = BR_EQ;
                    end
                    F3_BNE: begin
                        dec.op      = ALU_SUB;
                        dec.is_sub  = 1'b1;
                        dec.br_kind = BR_NE;
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            CLS_R: begin
                case (funct3)
                    F3_ADD: begin
                        if (funct7_5) begin
                            dec.op     = ALU_SUB;
                            dec.is_sub = 1'b1;
                        end else begin
                            dec.op = ALU_ADD;
                        end
                    end
                    F3_OR:   dec.op = ALU_OR;
                    F3_AND:  dec.op = ALU_AND;
                    default: dec.illegal = 1'b1;
                endcase
            end
            default: begin  // CLS_I, funct7_5 is not part of the encoding
                dec.b_imm = 1'b1;
                case (funct3)
                    F3_ADD:  dec.op = ALU_ADD;
                    F3_OR:   dec.op = ALU_OR;
                    F3_AND:  dec.op = ALU_AND;
                    default: dec.illegal = 1'b1;
                endcase
            end
        endcase

        // An illegal instruction travels as a harmless ADD of zeros
        if (dec.illegal) begin
            dec.op      = ALU_ADD;
            dec.b_imm   = 1'b0;
            dec.is_sub  = 1'b0;
            dec.br_kind = BR_NONE;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Two-stage execute front: E1 registers operands/opcode for the external
// ALU, E2 captures the ALU result and resolves branches. valid/ready on
// both sides; flush squashes both stages.
module alu_issue_stage (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    alu_issue_stage_if.slave  bus
);
    import alu_issue_stage_pkg::*;

    decode_t         dec;

    // E1 state (operand registers drive the ALU directly)
    logic            e1_valid_reg;
    logic [XLEN-1:0] alu_a_reg;
    logic [XLEN-1:0] alu_b_reg;
    logic [3:0]      alu_op_reg;
    logic [4:0]      e1_rd_reg;
    br_kind_e        e1_br_reg;
    logic            e1_illegal_reg;

    // E2 state
    logic            out_valid_reg;
    logic [XLEN-1:0] out_result_reg;
    logic [4:0]      out_rd_reg;
    logic            out_branch_reg;
    logic            out_taken_reg;
    logic            out_illegal_reg;

    // handshake and next-value wires
    logic            e2_adv;
    logic            in_ready;
    logic            e1_load;
    logic            e2_load;
    logic [XLEN-1:0] alu_a_next;
    logic [XLEN-1:0] alu_b_next;
    logic [XLEN-1:0] b_src;
    logic            taken_next;

    alu_op_decode u_decode (
        .cls      (bus.in_class),
        .funct3   (bus.in_funct3),
        .funct7_5 (bus.in_funct7_5),
        .dec      (dec)
    );

    // E2 can take a new entry when empty or being drained; E1 when empty or moving on
    assign e2_adv   = !out_valid_reg || bus.out_ready;
    assign in_ready = !e1_valid_reg || e2_adv;
    assign e1_load  = bus.in_valid && in_ready && !flush;
    assign e2_load  = e1_valid_reg && e2_adv && !flush;

    // Operand selection; SUB pre-decrements B because the ALU computes A + ~B
    always_comb begin
        b_src      = dec.b_imm ? bus.in_imm : bus.in_rs2;
        alu_a_next = bus.in_rs1;
        alu_b_next = dec.is_sub ? (b_src - 64'd1) : b_src;
        if (dec.illegal) begin
            alu_a_next = '0;
            alu_b_next = '0;
        end
    end

    assign taken_next = branch_taken(e1_br_reg, bus.alu_zero);

    // Valid bits: flush wins over accept and advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e1_valid_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else if (flush) begin
            e1_valid_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            if (in_ready) begin
                e1_valid_reg <= bus.in_valid;
            end
            if (e2_adv) begin
                out_valid_reg <= e1_valid_reg;
            end
        end
    end

    // E1 data: load the selected operands and opcode on accept, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            alu_op_reg     <= ALU_ADD;
            e1_rd_reg      <= '0;
            e1_br_reg      <= BR_NONE;
            e1_illegal_reg <= 1'b0;
        end else if (e1_load) begin
            alu_a_reg      <= alu_a_next;
            alu_b_reg      <= alu_b_next;
            alu_op_reg     <= dec.op;
            e1_rd_reg      <= bus.in_rd;
            e1_br_reg      <= dec.br_kind;
            e1_illegal_reg <= dec.illegal;
        end
    end

    // E2 data: capture the ALU result and resolve the branch on advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result_reg  <= '0;
            out_rd_reg      <= '0;
            out_branch_reg  <= 1'b0;
            out_taken_reg   <= 1'b0;
            out_illegal_reg <= 1'b0;
        end else if (e2_load) begin
            out_result_reg  <= bus.alu_result;
            out_rd_reg      <= e1_rd_reg;
            out_branch_reg  <= (e1_br_reg != BR_NONE);
            out_taken_reg   <= taken_next;
            out_illegal_reg <= e1_illegal_reg;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.alu_a       = alu_a_reg;
    assign bus.alu_b       = alu_b_reg;
    assign bus.alu_op      = alu_op_reg;
    assign bus.out_valid   = out_valid_reg;
    assign bus.out_result  = out_result_reg;
    assign bus.out_rd      = out_rd_reg;
    assign bus.out_branch  = out_branch_reg;
    assign bus.out_taken   = out_taken_reg;
    assign bus.out_illegal = out_illegal_reg;

endmodule
